// File: rtl/fc_bank_rotator.sv
// N-bank rotating buffer manager: the writer fills banks in ring order while the FC
// engine consumes full banks oldest-first. Both ports are routed to their current banks.
module fc_bank_rotator #(
  parameter int          NBANK        = 3,
  parameter int          BATCH        = 9,
  parameter int          AF           = 3,
  parameter int          DATA_WIDTH   = 8,
  parameter int          ADDR_WIDTH   = 32,
  parameter int unsigned IDLE_RD_ADDR = 8429
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         writer_en,
  input  logic                         writer_done,
  output logic                         FC_data_valid,
  input  logic                         FC_buffer_switch,
  output logic [$clog2(NBANK)-1:0]     wr_bank,
  output logic [$clog2(NBANK)-1:0]     rd_bank,
  output logic [$clog2(NBANK+1)-1:0]   occupancy,
  output logic                         err_sticky,
  output logic [1:0]                   fsm_state,
  input  logic [ADDR_WIDTH-1:0]        RAM_writer_wr_ADDR [BATCH],
  input  logic [AF-1:0]                RAM_writer_byte_en [BATCH],
  input  logic [AF*DATA_WIDTH-1:0]     RAM_writer_wr_data [BATCH],
  input  logic [ADDR_WIDTH-1:0]        FC_ram_rd_ADDR,
  output logic [AF*DATA_WIDTH-1:0]     FC_ram_rd_data [BATCH],
  input  logic [ADDR_WIDTH-1:0]        FC_ram_wr_ADDR,
  input  logic [AF-1:0]                FC_ram_byte_en,
  input  logic [AF*DATA_WIDTH-1:0]     FC_ram_wr_data [BATCH],
  output logic [ADDR_WIDTH-1:0]        bank_rd_ADDR [NBANK][BATCH],
  output logic [ADDR_WIDTH-1:0]        bank_wr_ADDR [NBANK][BATCH],
  output logic [AF-1:0]                bank_byte_en [NBANK][BATCH],
  output logic [AF*DATA_WIDTH-1:0]     bank_wr_data [NBANK][BATCH],
  input  logic [AF*DATA_WIDTH-1:0]     bank_rd_data [NBANK][BATCH]
);
  localparam int PW = $clog2(NBANK);
  localparam int OW = $clog2(NBANK+1);
  localparam logic [ADDR_WIDTH-1:0] IDLE_ADDR = ADDR_WIDTH'(IDLE_RD_ADDR);

  typedef enum logic {W_IDLE, W_BUSY}  w_state_t;
  typedef enum logic {F_IDLE, F_VALID} f_state_t;

  w_state_t          w_state, w_state_nxt;
  f_state_t          f_state, f_state_nxt;
  logic [OW-1:0]     full_cnt, full_cnt_nxt, occ_nxt;
  logic [PW-1:0]     wr_bank_nxt, rd_bank_nxt;
  logic              grant, done_ok, sw_ok, done_err, sw_err;

  function automatic logic [PW-1:0] ring_inc(input logic [PW-1:0] p);
    return (p == PW'(NBANK - 1)) ? '0 : p + PW'(1);
  endfunction

  // State register: every counter and pointer, including the registered grant pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state    <= W_IDLE;
      f_state    <= F_IDLE;
      writer_en  <= 1'b0;
      wr_bank    <= '0;
      rd_bank    <= '0;
      occupancy  <= '0;
      full_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      w_state    <= w_state_nxt;
      f_state    <= f_state_nxt;
      writer_en  <= grant;
      wr_bank    <= wr_bank_nxt;
      rd_bank    <= rd_bank_nxt;
      occupancy  <= occ_nxt;
      full_cnt   <= full_cnt_nxt;
      err_sticky <= err_sticky | done_err | sw_err;
    end
  end

  // Next state. Pulses arriving in the wrong state only flag an error.
  always_comb begin
    grant    = (w_state == W_IDLE) && (occupancy < OW'(NBANK));
    done_ok  = writer_done && (w_state == W_BUSY);
    done_err = writer_done && (w_state != W_BUSY);
    sw_ok    = FC_buffer_switch && (f_state == F_VALID);
    sw_err   = FC_buffer_switch && (f_state != F_VALID);

    w_state_nxt = w_state;
    if (grant)   w_state_nxt = W_BUSY;
    if (done_ok) w_state_nxt = W_IDLE;

    f_state_nxt = f_state;
    if (f_state == F_IDLE && full_cnt != '0) f_state_nxt = F_VALID;
    if (sw_ok)                               f_state_nxt = F_IDLE;

    wr_bank_nxt  = done_ok ? ring_inc(wr_bank) : wr_bank;
    rd_bank_nxt  = sw_ok   ? ring_inc(rd_bank) : rd_bank;
    occ_nxt      = occupancy + OW'(grant)   - OW'(sw_ok);
    full_cnt_nxt = full_cnt  + OW'(done_ok) - OW'(sw_ok);
  end

  // Outputs and bank routing, driven purely from registered state.
  always_comb begin
    FC_data_valid = (f_state == F_VALID);
    fsm_state     = {f_state == F_VALID, w_state == W_BUSY};
    for (int l = 0; l < BATCH; l++) FC_ram_rd_data[l] = '0;
    for (int b = 0; b < NBANK; b++) begin
      for (int l = 0; l < BATCH; l++) begin
        bank_rd_ADDR[b][l] = IDLE_ADDR;
        bank_wr_ADDR[b][l] = '0;
        bank_byte_en[b][l] = '0;
        bank_wr_data[b][l] = '0;
        if (w_state == W_BUSY && wr_bank == PW'(b)) begin
          bank_wr_ADDR[b][l] = RAM_writer_wr_ADDR[l];
          bank_byte_en[b][l] = RAM_writer_byte_en[l];
          bank_wr_data[b][l] = RAM_writer_wr_data[l];
        end
        if (f_state == F_VALID && rd_bank == PW'(b)) begin
          bank_rd_ADDR[b][l] = FC_ram_rd_ADDR;
          bank_wr_ADDR[b][l] = FC_ram_wr_ADDR;
          bank_byte_en[b][l] = FC_ram_byte_en;
          bank_wr_data[b][l] = FC_ram_wr_data[l];
        end
      end
    end
    if (f_state == F_VALID) begin
      for (int l = 0; l < BATCH; l++) FC_ram_rd_data[l] = bank_rd_data[rd_bank][l];
    end
  end

  // The filling bank and the consumed bank can never coincide.
  assert property (@(posedge clk) disable iff (rst)
    !(w_state == W_BUSY && f_state == F_VALID && wr_bank == rd_bank));

endmodule

// File: tb/tb_fc_bank_rotator.sv
// Randomized bench for fc_bank_rotator against a bank-ownership model (FIFO of full banks).
module tb_fc_bank_rotator;
  localparam int NBANK = 3;
  localparam int BATCH = 9;
  localparam int AF = 3;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int DW = AF * DATA_WIDTH;
  localparam int IDLE = 8429;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic writer_en, writer_done = 1'b0, FC_data_valid, FC_buffer_switch = 1'b0;
  logic [$clog2(NBANK)-1:0] wr_bank, rd_bank;
  logic [$clog2(NBANK+1)-1:0] occupancy;
  logic err_sticky;
  logic [1:0] fsm_state;
  logic [ADDR_WIDTH-1:0] RAM_writer_wr_ADDR [BATCH];
  logic [AF-1:0]         RAM_writer_byte_en [BATCH];
  logic [DW-1:0]         RAM_writer_wr_data [BATCH];
  logic [ADDR_WIDTH-1:0] FC_ram_rd_ADDR, FC_ram_wr_ADDR;
  logic [DW-1:0]         FC_ram_rd_data [BATCH];
  logic [AF-1:0]         FC_ram_byte_en;
  logic [DW-1:0]         FC_ram_wr_data [BATCH];
  logic [ADDR_WIDTH-1:0] bank_rd_ADDR [NBANK][BATCH];
  logic [ADDR_WIDTH-1:0] bank_wr_ADDR [NBANK][BATCH];
  logic [AF-1:0]         bank_byte_en [NBANK][BATCH];
  logic [DW-1:0]         bank_wr_data [NBANK][BATCH];
  logic [DW-1:0]         bank_rd_data [NBANK][BATCH];

  fc_bank_rotator #(
    .NBANK(NBANK), .BATCH(BATCH), .AF(AF), .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .IDLE_RD_ADDR(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .writer_en(writer_en), .writer_done(writer_done),
    .FC_data_valid(FC_data_valid), .FC_buffer_switch(FC_buffer_switch),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .occupancy(occupancy),
    .err_sticky(err_sticky), .fsm_state(fsm_state),
    .RAM_writer_wr_ADDR(RAM_writer_wr_ADDR), .RAM_writer_byte_en(RAM_writer_byte_en),
    .RAM_writer_wr_data(RAM_writer_wr_data), .FC_ram_rd_ADDR(FC_ram_rd_ADDR),
    .FC_ram_rd_data(FC_ram_rd_data), .FC_ram_wr_ADDR(FC_ram_wr_ADDR),
    .FC_ram_byte_en(FC_ram_byte_en), .FC_ram_wr_data(FC_ram_wr_data),
    .bank_rd_ADDR(bank_rd_ADDR), .bank_wr_ADDR(bank_wr_ADDR),
    .bank_byte_en(bank_byte_en), .bank_wr_data(bank_wr_data),
    .bank_rd_data(bank_rd_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Model: which bank the writer holds, plus the FIFO of full banks awaiting/under FC use.
  int m_wr = 0;
  bit m_busy = 1'b0, m_valid = 1'b0, m_en = 1'b0, m_err = 1'b0;
  int full_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit d, input bit s);
    int occ;
    bit grant, start;
    if (r) begin
      m_wr = 0; m_busy = 0; m_valid = 0; m_en = 0; m_err = 0;
      full_q.delete();
      return;
    end
    occ   = int'(m_busy) + full_q.size();
    grant = !m_busy && occ < NBANK;
    start = !m_valid && full_q.size() > 0;
    if (d && !m_busy)  m_err = 1;
    if (s && !m_valid) m_err = 1;
    if (s && m_valid) begin
      void'(full_q.pop_front());
      m_valid = 0;
    end else if (start) m_valid = 1;
    if (d && m_busy) begin
      full_q.push_back(m_wr);
      m_wr = (m_wr + 1) % NBANK;
      m_busy = 0;
    end else if (grant) m_busy = 1;
    m_en = grant;
  endtask

  task automatic drive_data();
    for (int l = 0; l < BATCH; l++) begin
      RAM_writer_wr_ADDR[l] = $urandom();
      RAM_writer_byte_en[l] = AF'($urandom());
      RAM_writer_wr_data[l] = DW'($urandom());
      FC_ram_wr_data[l]     = DW'($urandom());
      for (int b = 0; b < NBANK; b++) bank_rd_data[b][l] = DW'($urandom());
    end
    FC_ram_rd_ADDR = $urandom();
    FC_ram_wr_ADDR = $urandom();
    FC_ram_byte_en = AF'($urandom());
  endtask

  // Compare every DUT output with the model for the current cycle.
  task automatic compare_all();
    int bad, rb;
    logic [ADDR_WIDTH-1:0] e_ra, e_wa;
    logic [AF-1:0] e_be;
    logic [DW-1:0] e_wd;
    check("writer_en", writer_en, m_en);
    check("FC_data_valid", FC_data_valid, m_valid);
    check("wr_bank", wr_bank, m_wr);
    check("rd_bank", rd_bank, (m_wr + NBANK - full_q.size()) % NBANK);
    check("occupancy", occupancy, int'(m_busy) + full_q.size());
    check("err_sticky", err_sticky, m_err);
    check("fsm_state", fsm_state, {m_valid, m_busy});
    rb = (full_q.size() > 0) ? full_q[0] : 0;
    for (int b = 0; b < NBANK; b++) begin
      bad = 0;
      for (int l = 0; l < BATCH; l++) begin
        e_ra = IDLE; e_wa = '0; e_be = '0; e_wd = '0;
        if (m_busy && b == m_wr) begin
          e_wa = RAM_writer_wr_ADDR[l]; e_be = RAM_writer_byte_en[l]; e_wd = RAM_writer_wr_data[l];
        end
        if (m_valid && b == rb) begin
          e_ra = FC_ram_rd_ADDR; e_wa = FC_ram_wr_ADDR; e_be = FC_ram_byte_en; e_wd = FC_ram_wr_data[l];
        end
        if (bank_rd_ADDR[b][l] !== e_ra) bad++;
        if (bank_wr_ADDR[b][l] !== e_wa) bad++;
        if (bank_byte_en[b][l] !== e_be) bad++;
        if (bank_wr_data[b][l] !== e_wd) bad++;
      end
      check($sformatf("bank%0d_route_bad_fields", b), bad, 0);
    end
    bad = 0;
    for (int l = 0; l < BATCH; l++)
      if (FC_ram_rd_data[l] !== (m_valid ? bank_rd_data[rb][l] : DW'(0))) bad++;
    check("fc_rd_data_bad_lanes", bad, 0);
  endtask

  // Driver: one clock cycle with the given control pulses.
  task automatic cyc(input bit r, input bit d, input bit s);
    @(negedge clk);
    rst = r; writer_done = d; FC_buffer_switch = s;
    drive_data();
    #1;
    if (checking) compare_all();
    @(posedge clk);
    model_edge(r, d, s);
    #1;
  endtask

  initial begin
    bit r, d, s;
    drive_data();
    // Directed sequence with hand-computed expectations.
    cyc(1, 0, 0);
    checking = 1'b1;
    cyc(1, 0, 0);
    check("rst_writer_en", writer_en, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_valid", FC_data_valid, 0);
    check("rst_err", err_sticky, 0);
    cyc(0, 0, 0);
    check("first_grant", writer_en, 1);
    check("first_wr_bank", wr_bank, 0);
    check("first_occ", occupancy, 1);
    cyc(0, 0, 0);
    check("grant_one_cycle", writer_en, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("bank0_valid", FC_data_valid, 1);
    check("bank0_rd_bank", rd_bank, 0);
    check("bank0_byte_en", bank_byte_en[0][0], FC_ram_byte_en);
    check("bank1_idle_rd_addr", bank_rd_ADDR[1][0], IDLE);
    check("bank0_rd_addr_lane3", bank_rd_ADDR[0][3], FC_ram_rd_ADDR);
    check("second_occ", occupancy, 2);
    cyc(0, 1, 1);
    check("simul_rd_bank", rd_bank, 1);
    check("simul_wr_bank", wr_bank, 2);
    check("simul_no_err", err_sticky, 0);
    cyc(0, 1, 0);
    check("idle_done_err", err_sticky, 1);
    check("idle_done_wr_bank", wr_bank, 2);
    check("idle_done_rd_bank", rd_bank, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    check("full_occ", occupancy, 3);
    check("full_no_grant", writer_en, 0);
    cyc(0, 0, 1);
    check("freed_rd_bank", rd_bank, 2);
    check("freed_no_grant_yet", writer_en, 0);
    cyc(0, 0, 0);
    check("freed_grant", writer_en, 1);
    check("freed_wr_bank", wr_bank, 1);
    cyc(0, 0, 1);
    check("pre_rst_occ", occupancy, 2);
    cyc(1, 0, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_wr_bank", wr_bank, 0);
    check("mid_rst_rd_bank", rd_bank, 0);
    check("mid_rst_err", err_sticky, 0);
    check("mid_rst_be", bank_byte_en[1][0], 0);
    cyc(0, 0, 0);
    check("post_rst_grant", writer_en, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      d = m_busy  ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      s = m_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      cyc(r, d, s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
